// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: bundles the raw PS/2 lines and the decoded key outputs.
// Handshake: scan_valid, key_press and frame_err are single-cycle strobes with
// no back-pressure (no ready). A consumer must take scan_code in the cycle
// scan_valid is high. key_state is a level that holds between changes.
// fsm_state is a debug view of the frame deserializer (0 = IDLE).
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] key_state;
  logic [9:0] key_press;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic [1:0] fsm_state;

  // Keyboard side / checker: drives the PS/2 lines, observes decoded outputs.
  modport master (
    output ps2_clk, ps2_data,
    input  key_state, key_press, scan_code, scan_valid, frame_err, fsm_state
  );

  // Decoder side.
  modport slave (
    input  ps2_clk, ps2_data,
    output key_state, key_press, scan_code, scan_valid, frame_err, fsm_state
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 device-to-host receiver plus scan-code set 2 decoder.
// Raw lines are synchronized, ps2_clk is glitch-filtered, 11-bit frames are
// deserialized on filtered falling edges, and make/break sequences drive a
// 10-bit held-key bitmap with one-cycle press pulses.
// Optional feature: define PS2_PARITY_CHECK_EN to drop frames whose odd
// parity fails; otherwise the parity bit is skipped.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_key_decoder_if.slave  bus
);

  localparam int FW  = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic          clk_s1_q, clk_s2_q;
  logic          data_s1_q, data_s2_q;
  logic          filt_clk_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall_q;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [WDW-1:0] wd_q;
  logic [7:0]    scan_code_q;
  logic          scan_valid_q;
  logic          frame_err_q;
  logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q;
`endif

  logic [9:0]    key_state_q;
  logic [9:0]    key_press_q;
  logic          ext_q, brk_q;
  logic          key_hit;
  logic [3:0]    key_idx;

  // Two-flop synchronizers for both raw lines; idle PS/2 lines are high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= bus.ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= bus.ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  // Clock filter: follow the synchronized clock only after FILTER_LEN
  // consecutive differing samples; emit a one-cycle pulse on a filtered fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s2_q != filt_clk_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_clk_q <= clk_s2_q;
          filt_cnt_q <= '0;
          fall_q     <= ~clk_s2_q;
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  // Stop bit must be high; with checking enabled, the 9 bits must hold odd parity.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = data_s2_q & (^{shift_q, par_q});
`else
  assign frame_ok = data_s2_q;
`endif

  // Frame deserializer with watchdog; scan_code/scan_valid/frame_err registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      wd_q         <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall_q) begin
        wd_q <= '0;
        unique case (state_q)
          S_IDLE: begin
            if (!data_s2_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          S_DATA: begin
            shift_q   <= {data_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= data_s2_q;
`endif
            state_q <= S_STOP;
          end
          S_STOP: begin
            if (frame_ok) begin
              scan_code_q  <= shift_q;
              scan_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        // A stalled keyboard must not leave a half-received byte pending forever.
        if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          frame_err_q <= 1'b1;
          state_q     <= S_IDLE;
          wd_q        <= '0;
        end else begin
          wd_q <= wd_q + WDW'(1);
        end
      end else begin
        wd_q <= '0;
      end
    end
  end

  // Scan-code lookup; bit 8 of the key is the E0 (extended) flag.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    case ({ext_q, scan_code_q})
      9'h01D:  key_idx = 4'd0;
      9'h01B:  key_idx = 4'd1;
      9'h01C:  key_idx = 4'd2;
      9'h023:  key_idx = 4'd3;
      9'h175:  key_idx = 4'd4;
      9'h172:  key_idx = 4'd5;
      9'h16B:  key_idx = 4'd6;
      9'h174:  key_idx = 4'd7;
      9'h076:  key_idx = 4'd8;
      9'h029:  key_idx = 4'd9;
      default: key_hit = 1'b0;
    endcase
  end

  // Make/break decoder: prefixes arm ext/brk, any other byte consumes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_state_q <= '0;
      key_press_q <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      key_press_q <= '0;
      if (frame_err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (scan_valid_q) begin
        if (scan_code_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (scan_code_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (key_hit) begin
            if (brk_q) begin
              key_state_q[key_idx] <= 1'b0;
            end else begin
              key_state_q[key_idx] <= 1'b1;
              // Typematic repeats of a held key do not pulse again.
              key_press_q[key_idx] <= ~key_state_q[key_idx];
            end
          end
        end
      end
    end
  end

  assign bus.key_state  = key_state_q;
  assign bus.key_press  = key_press_q;
  assign bus.scan_code  = scan_code_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.fsm_state  = state_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard clock/data lines, deframes 11-bit PS/2 device-to-host frames, and decodes scan-code set 2 make/break sequences into a held-key bitmap plus one-cycle press pulses. Sits upstream of the VGA output controller. Replaces the separate keyboard-receiver/per-key instances with one block that drives player 1/2 direction bits, pause (SPACE) and restart (ESC) directly. Host-to-device transmission is out of scope; PS/2 lines are input-only here.

## Interface
- FILTER_LEN, 4: consecutive identical synchronized samples required before filtered ps2_clk changes.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered falling edge before an in-progress frame is aborted (2 ms at 50 MHz).
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- key_state  out  10  held-key bitmap: [0]W 1D, [1]S 1B, [2]A 1C, [3]D 23, [4]UP E0 75, [5]DOWN E0 72, [6]LEFT E0 6B, [7]RIGHT E0 74, [8]ESC 76, [9]SPACE 29.
- key_press  out  10  one-cycle pulse per bit on a 0->1 transition of key_state.
- scan_code  out  8  last accepted frame byte; holds until next accepted byte.
- scan_valid  out  1  one-cycle pulse when scan_code is updated.
- frame_err  out  1  one-cycle pulse on a dropped frame (bad stop, timeout, or parity when enabled).

## Operation
- Input path: ps2_clk and ps2_data each pass through 2-flop synchronizers. Filtered clock changes only after FILTER_LEN equal samples. The frame FSM advances only on a filtered falling edge, sampling synchronized ps2_data in that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: data=0 -> DATA, bit counter=0. data=1 -> stay in IDLE, no error.
  - DATA: shift LSB-first; after the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: data=1 (and parity passes, when checked) -> accept byte; otherwise frame_err. Both outcomes -> IDLE.
- Timeout: in any state other than IDLE, a watchdog counts cycles since the last filtered falling edge. At TIMEOUT_CYCLES: frame_err, FSM -> IDLE, partial byte discarded. The counter resets on every falling edge and in IDLE.
- Decoder (runs on each accepted byte):
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte is looked up with the current ext flag.
    - Match with brk=0: set key_state bit. key_press pulses only if the bit was 0, so typematic repeats give no pulse.
    - Match with brk=1: clear the bit.
    - No match (including 0xAA, 0xFA, ext-mismatched codes): no change.
  - ext and brk clear after every non-prefix byte, and after frame_err.
- Simultaneous events: a frame_err and a decode never occur in the same cycle. Multiple key bits never change in one cycle.
- Reset mid-frame: all state is discarded immediately. The next valid start bit after release begins a fresh frame.

## Timing
- Reset values: key_state=0, key_press=0, scan_code=0x00, scan_valid=0, frame_err=0, FSM=IDLE, ext=brk=0. Filtered clock is 1; synchronizers are 1.
- Raw ps2_clk falling edge -> FSM sample: 2 (sync) + FILTER_LEN cycles.
- Stop-bit sample cycle N: scan_valid and scan_code updated at N+1. key_state and key_press updated at N+2.
- frame_err asserts the cycle after the stop-bit sample or the timeout expiry.
- Pulses are exactly one clk wide. key_press is never asserted while reset is high.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity is checked over 8 data bits plus the parity bit. A mismatch drops the byte (no scan_valid) and pulses frame_err.
- PS2_PARITY_CHECK_EN undefined: the parity bit is captured and ignored. Only a bad stop bit or a timeout produces frame_err.

## Test plan
- Frame 0x29 (SPACE make), correct parity -> scan_valid once with scan_code=0x29. key_state[9]=1 and key_press[9] pulse 1 cycle later.
- Sequence E0 75, then E0 F0 75 -> key_state[4] rises, then falls. key_press[4] pulses once. key_state[0] (W, 0x1D) and all other bits stay 0.
- 0x1D sent three times (typematic) -> key_state[0]=1 with exactly one key_press[0] pulse. A later F0 1D clears bit 0.
- Frame 0x76 with parity flipped -> with PS2_PARITY_CHECK_EN: frame_err pulse, no scan_valid, key_state[8]=0. Without it: key_state[8]=1.
- Stop after 5 data bits, idle 100000 cycles -> frame_err pulse, FSM back in IDLE. A following valid 0x1C frame sets key_state[2].
- 2-cycle glitch on ps2_clk with FILTER_LEN=4 -> no bit sampled. Reset asserted mid-frame -> all outputs 0; the next frame decodes correctly.
